// File: rtl/sec_ded_decoder.sv
`timescale 1ns/1ps
// SEC-DED read-side checker/corrector for 8 data + 5 check bits (Hamming(12,8) + overall parity).
// Latency: 2 cycles (syndrome stage, classify/correct stage), 1 word/cycle when outReady is held high.
// Backpressure: each stage holds its word while downstream stalls; inReady drops once both stages are full.
module sec_ded_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RSTb,
    input  logic [7:0]       dataIn,
    input  logic [4:0]       checkIn,
    input  logic             inValid,
    output logic             inReady,
    output logic [7:0]       dataOut,
    output logic [3:0]       syndromeOut,
    output logic             secOut,
    output logic             dedOut,
`ifdef SEC_DED_ERR_CNT_EN
    input  logic             clrCnt,
    output logic [CNT_W-1:0] secCnt,
    output logic [CNT_W-1:0] dedCnt,
`endif
    output logic             outValid,
    input  logic             outReady
);

    logic       s1_vld;
    logic [7:0] s1_dat;
    logic [3:0] s1_syn;
    logic       s1_op;
    logic       s2_adv;
    logic [3:0] p_calc;
    logic [7:0] flip_mask;
    logic [7:0] dat_nxt;
    logic       sec_nxt;
    logic       ded_nxt;

    assign s2_adv  = !outValid || outReady;
    assign inReady = !s1_vld || s2_adv;

    // checkIn[3:0] holds {p8,p4,p2,p1}; data bit dN sits at code positions 3,5,6,7,9,10,11,12.
    always_comb begin
        p_calc[0] = dataIn[0] ^ dataIn[1] ^ dataIn[3] ^ dataIn[4] ^ dataIn[6];
        p_calc[1] = dataIn[0] ^ dataIn[2] ^ dataIn[3] ^ dataIn[5] ^ dataIn[6];
        p_calc[2] = dataIn[1] ^ dataIn[2] ^ dataIn[3] ^ dataIn[7];
        p_calc[3] = dataIn[4] ^ dataIn[5] ^ dataIn[6] ^ dataIn[7];
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
            s1_syn <= '0;
            s1_op  <= 1'b0;
        end else if (inReady) begin
            s1_vld <= inValid;
            if (inValid) begin
                s1_dat <= dataIn;
                s1_syn <= p_calc ^ checkIn[3:0];
                s1_op  <= ^{dataIn, checkIn};
            end
        end
    end

    // Syndromes naming a check-bit position (1,2,4,8) leave the mask empty: nothing to fix in data.
    always_comb begin
        flip_mask = 8'h00;
        case (s1_syn)
            4'd3:    flip_mask = 8'h01;
            4'd5:    flip_mask = 8'h02;
            4'd6:    flip_mask = 8'h04;
            4'd7:    flip_mask = 8'h08;
            4'd9:    flip_mask = 8'h10;
            4'd10:   flip_mask = 8'h20;
            4'd11:   flip_mask = 8'h40;
            4'd12:   flip_mask = 8'h80;
            default: flip_mask = 8'h00;
        endcase
    end

    always_comb begin
        dat_nxt = s1_dat;
        sec_nxt = 1'b0;
        ded_nxt = 1'b0;
        if (s1_syn == 4'd0) begin
            sec_nxt = s1_op;
        end else if (s1_op && (s1_syn <= 4'd12)) begin
            sec_nxt = 1'b1;
            dat_nxt = s1_dat ^ flip_mask;
        end else begin
            ded_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            outValid    <= 1'b0;
            dataOut     <= '0;
            syndromeOut <= '0;
            secOut      <= 1'b0;
            dedOut      <= 1'b0;
        end else if (s2_adv) begin
            outValid <= s1_vld;
            if (s1_vld) begin
                dataOut     <= dat_nxt;
                syndromeOut <= s1_syn;
                secOut      <= sec_nxt;
                dedOut      <= ded_nxt;
            end
        end
    end

`ifdef SEC_DED_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic out_hs;
    assign out_hs = outValid && outReady;

    // Clear has priority over an increment landing in the same cycle.
    always_ff @(posedge CLK) begin
        if (!RSTb || clrCnt) begin
            secCnt <= '0;
            dedCnt <= '0;
        end else begin
            if (out_hs && secOut && (secCnt != CNT_MAX))
                secCnt <= secCnt + CNT_W'(1);
            if (out_hs && dedOut && (dedCnt != CNT_MAX))
                dedCnt <= dedCnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sec_ded_decoder.sv
`timescale 1ns/1ps
// Scoreboard bench for sec_ded_decoder: stimulus pushes hand-computed results, a monitor pops on each output handshake.
module tb_sec_ded_decoder;

    localparam int CNT_W = 2;

`ifdef SEC_DED_ERR_CNT_EN
    logic             clrCnt;
    logic [CNT_W-1:0] secCnt;
    logic [CNT_W-1:0] dedCnt;
    logic [CNT_W-1:0] m_sec;
    logic [CNT_W-1:0] m_ded;
`endif

    logic       CLK = 1'b0;
    logic       RSTb;
    logic [7:0] dataIn;
    logic [4:0] checkIn;
    logic       inValid;
    logic       inReady;
    logic [7:0] dataOut;
    logic [3:0] syndromeOut;
    logic       secOut;
    logic       dedOut;
    logic       outValid;
    logic       outReady;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] s;
        logic       sec;
        logic       ded;
    } exp_t;

    exp_t sbq[$];
    int   nvec = 0;
    int   nerr = 0;
    logic hold_vld = 1'b0;
    exp_t hold_val;

    sec_ded_decoder #(.CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .RSTb        (RSTb),
        .dataIn      (dataIn),
        .checkIn     (checkIn),
        .inValid     (inValid),
        .inReady     (inReady),
        .dataOut     (dataOut),
        .syndromeOut (syndromeOut),
        .secOut      (secOut),
        .dedOut      (dedOut),
`ifdef SEC_DED_ERR_CNT_EN
        .clrCnt      (clrCnt),
        .secCnt      (secCnt),
        .dedCnt      (dedCnt),
`endif
        .outValid    (outValid),
        .outReady    (outReady)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that accepted the word.
    task automatic send(input logic [7:0] d, input logic [4:0] c, input exp_t e);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        dataIn  = d;
        checkIn = c;
        inValid = 1'b1;
        while (!done) begin
            @(negedge CLK);
            if (inReady) begin
                sbq.push_back(e);
                done = 1'b1;
            end
            @(posedge CLK);
            #1;
            n++;
            if (!done && n > 50) begin
                nvec++;
                nerr++;
                $display("FAIL send_timeout: inReady stuck at 0, want 1 within 50 cycles");
                done = 1'b1;
            end
        end
        inValid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(posedge CLK);
            n++;
        end
        if (sbq.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL drain_timeout: %0d words still pending, want 0", sbq.size());
        end
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compares at falling edges so every DUT output has settled.
    initial begin
        exp_t got;
        exp_t e;
`ifdef SEC_DED_ERR_CNT_EN
        m_sec = '0;
        m_ded = '0;
`endif
        forever begin
            @(negedge CLK);
            if (RSTb !== 1'b1) begin
                hold_vld = 1'b0;
`ifdef SEC_DED_ERR_CNT_EN
                m_sec = '0;
                m_ded = '0;
`endif
            end else begin
                got = {dataOut, syndromeOut, secOut, dedOut};
`ifdef SEC_DED_ERR_CNT_EN
                check("secCnt", 32'(secCnt), 32'(m_sec));
                check("dedCnt", 32'(dedCnt), 32'(m_ded));
`endif
                if (hold_vld)
                    check("stall_hold", 32'(got), 32'(hold_val));
                if (outValid && outReady) begin
                    hold_vld = 1'b0;
                    if (sbq.size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL unexpected_output: got %0h, want no word", got);
                    end else begin
                        e = sbq.pop_front();
                        check("word{d,s,sec,ded}", 32'(got), 32'(e));
`ifdef SEC_DED_ERR_CNT_EN
                        if (e.sec && m_sec != '1) m_sec = m_sec + 1'b1;
                        if (e.ded && m_ded != '1) m_ded = m_ded + 1'b1;
`endif
                    end
                end else if (outValid) begin
                    hold_vld = 1'b1;
                    hold_val = got;
                end else begin
                    hold_vld = 1'b0;
                end
`ifdef SEC_DED_ERR_CNT_EN
                if (clrCnt) begin
                    m_sec = '0;
                    m_ded = '0;
                end
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000 ns, want finish");
        $fatal(1);
    end

    initial begin
        RSTb     = 1'b0;
        inValid  = 1'b0;
        dataIn   = '0;
        checkIn  = '0;
        outReady = 1'b1;
`ifdef SEC_DED_ERR_CNT_EN
        clrCnt   = 1'b0;
`endif
        repeat (2) @(posedge CLK);
        #1 RSTb = 1'b1;

        @(negedge CLK);
        check("rst_inReady",  32'(inReady),     32'd1);
        check("rst_outValid", 32'(outValid),    32'd0);
        check("rst_dataOut",  32'(dataOut),     32'd0);
        check("rst_syndrome", 32'(syndromeOut), 32'd0);
        check("rst_secOut",   32'(secOut),      32'd0);
        check("rst_dedOut",   32'(dedOut),      32'd0);
        @(posedge CLK);
        #1;

        // Back-to-back directed words: {data, syndrome, sec, ded} expected.
        send(8'hA5, 5'h03, {8'hA5, 4'd0,  1'b0, 1'b0});
        send(8'hA1, 5'h03, {8'hA5, 4'd6,  1'b1, 1'b0});
        send(8'hA5, 5'h13, {8'hA5, 4'd0,  1'b1, 1'b0});
        send(8'hA6, 5'h03, {8'hA6, 4'd6,  1'b0, 1'b1});
        send(8'hA5, 5'h1C, {8'hA5, 4'd15, 1'b0, 1'b1});
        send(8'h25, 5'h03, {8'hA5, 4'd12, 1'b1, 1'b0});
        send(8'hA5, 5'h02, {8'hA5, 4'd1,  1'b1, 1'b0});
        send(8'hA5, 5'h0B, {8'hA5, 4'd8,  1'b1, 1'b0});
        send(8'hB5, 5'h03, {8'hA5, 4'd9,  1'b1, 1'b0});
        send(8'h00, 5'h00, {8'h00, 4'd0,  1'b0, 1'b0});
        send(8'h01, 5'h00, {8'h00, 4'd3,  1'b1, 1'b0});
        send(8'hFF, 5'h03, {8'hFF, 4'd0,  1'b0, 1'b0});
        send(8'hA5, 5'h12, {8'hA5, 4'd1,  1'b0, 1'b1});
        wait_drain();

        // Downstream stalls for three cycles while four words stream in.
        fork
            begin
                send(8'h00, 5'h00, {8'h00, 4'd0, 1'b0, 1'b0});
                send(8'hA1, 5'h03, {8'hA5, 4'd6, 1'b1, 1'b0});
                send(8'hFF, 5'h03, {8'hFF, 4'd0, 1'b0, 1'b0});
                send(8'h01, 5'h00, {8'h00, 4'd3, 1'b1, 1'b0});
            end
            begin
                outReady = 1'b0;
                repeat (3) @(negedge CLK);
                check("stall_inReady",  32'(inReady),  32'd0);
                check("stall_outValid", 32'(outValid), 32'd1);
                @(posedge CLK);
                #1 outReady = 1'b1;
            end
        join
        wait_drain();

`ifdef SEC_DED_ERR_CNT_EN
        // Clear lands on the same edge as the second word's handshake.
        send(8'hA1, 5'h03, {8'hA5, 4'd6, 1'b1, 1'b0});
        send(8'hA1, 5'h03, {8'hA5, 4'd6, 1'b1, 1'b0});
        send(8'hA1, 5'h03, {8'hA5, 4'd6, 1'b1, 1'b0});
        clrCnt = 1'b1;
        @(posedge CLK);
        #1 clrCnt = 1'b0;
        wait_drain();
`endif

        // Reset with two words in flight must discard them.
        outReady = 1'b0;
        send(8'hA5, 5'h03, {8'hA5, 4'd0, 1'b0, 1'b0});
        send(8'hA1, 5'h03, {8'hA5, 4'd6, 1'b1, 1'b0});
        RSTb = 1'b0;
        sbq.delete();
        @(posedge CLK);
        #1 RSTb = 1'b1;
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("flush_outValid", 32'(outValid), 32'd0);
        end
        @(posedge CLK);
        #1;
        send(8'hFF, 5'h03, {8'hFF, 4'd0, 1'b0, 1'b0});
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/sec_ded_decoder.md
Name: sec_ded_decoder

Overview:
- Read-side SEC-DED checker/corrector for the 8-bit data + 5-bit check word held in the memory block; it sits on the memory's dataOut/checkOut path.
- Recomputes the Hamming(12,8) syndrome and overall parity, corrects single-bit errors, and flags double-bit errors.
- Two-stage pipeline with valid/ready handshakes on both sides, plus optional saturating error counters.

Parameters:
- CNT_W, 8, width of each error counter (active only with the optional feature)

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RSTb  input  1  reset, synchronous, active-low
- dataIn  input  8  stored data bits d0..d7
- checkIn  input  5  stored check bits {p0,p8,p4,p2,p1}; p0 = overall parity
- inValid  input  1  dataIn/checkIn valid
- inReady  output  1  decoder accepts the word this cycle
- dataOut  output  8  corrected data
- syndromeOut  output  4  raw syndrome of the word presented
- secOut  output  1  single error detected and corrected
- dedOut  output  1  uncorrectable error detected; dataOut = raw dataIn
- outValid  output  1  output word valid
- outReady  input  1  downstream accepts the output word
- clrCnt  input  1  clear counters (optional feature only)
- secCnt  output  CNT_W  corrected-error count (optional feature only)
- dedCnt  output  CNT_W  uncorrectable-error count (optional feature only)

Behaviour:
- Code layout: positions 1..12. p1@1, p2@2, d0@3, p4@4, d1@5, d2@6, d3@7, p8@8, d4@9, d5@10, d6@11, d7@12.
- Check bits: pK = XOR of data at positions whose index has bit K set. p0 = XOR of d0..d7 and p1..p8 (even overall parity).
- Stage 1 (registered): captures data, syndrome s = {p8,p4,p2,p1} recomputed XOR stored, and op = XOR of all 13 input bits.
- Stage 2 (registered): classification and correction.
  - s=0, op=0: clean. sec=0, ded=0.
  - s=0, op=1: p0 bit in error. Data unchanged, sec=1.
  - s in 1..12, op=1: flip the bit at position s if it is a data position (no data change if s is 1, 2, 4 or 8). sec=1.
  - s in 13..15 with op=1, or s!=0 with op=0: ded=1, sec=0, data passed through uncorrected.
- Latency: 2 cycles from an accepted input (inValid&&inReady) to outValid, with no stall.
- Handshake:
  - Each stage advances when empty or when its downstream consumes.
  - inReady = !s1Valid || (!s2Valid || outReady); combinational from the stage state and outReady.
  - Output fields stay stable while outValid && !outReady.
  - Full throughput of 1 word/cycle when outReady is held at 1.
  - Stall: with outReady=0, two words are held (one per stage) and inReady drops to 0.
- Reset (RSTb=0 at an edge): s1Valid=s2Valid=0, dataOut=0, syndromeOut=0, secOut=0, dedOut=0, outValid=0; counters 0.
  - Reset mid-operation discards in-flight words with no partial output.
  - inReady=1 in the cycle after reset deasserts.

Optional Feature:
- Macro SEC_DED_ERR_CNT_EN.
- Defined:
  - secCnt/dedCnt increment by 1 on each output handshake (outValid&&outReady) whose secOut/dedOut is 1.
  - Counters saturate at 2^CNT_W-1.
  - clrCnt zeroes both next cycle; clrCnt wins over a same-cycle increment.
- Undefined: clrCnt, secCnt and dedCnt ports are absent and no counter logic is built.

Test Plan:
- Reset, then dataIn=0xA5, checkIn=0x03, outReady=1 -> 2 cycles later dataOut=0xA5, syndromeOut=0, secOut=0, dedOut=0.
- dataIn=0xA1 (d2 flipped), checkIn=0x03 -> dataOut=0xA5, syndromeOut=6, secOut=1, dedOut=0; with feature, secCnt=1.
- dataIn=0xA5, checkIn=0x13 (p0 flipped) -> dataOut=0xA5, syndromeOut=0, secOut=1.
- dataIn=0xA6 (d0,d1 flipped), checkIn=0x03 -> syndromeOut=6, dedOut=1, secOut=0, dataOut=0xA6.
- dataIn=0xA5, checkIn=0x1C -> syndromeOut=15, op=1, dedOut=1, dataOut=0xA5.
- Stream 4 words with outReady=0 for 3 cycles -> inReady=0 after 2 words accepted, outputs stable during the stall, no loss or duplication on release. With CNT_W=2: 5 sec words give secCnt=3, and clrCnt together with an increment gives 0.
